// File: rtl/fifo_spi_burst_sequencer_if.sv
// FIFO read port and SPI serializer load port seen by the burst sequencer.
// master = sequencer side, slave = FIFO/serializer side.
interface fifo_spi_burst_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 8
);
    logic [PTR_WIDTH:0]    fifo_count;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] spi_data;
    logic                  spi_start;
    logic                  spi_done;

    modport master (
        input  fifo_count, fifo_empty, fifo_rdata, spi_done,
        output fifo_rd_en, spi_data, spi_start
    );

    modport slave (
        output fifo_count, fifo_empty, fifo_rdata, spi_done,
        input  fifo_rd_en, spi_data, spi_start
    );
endinterface

// File: rtl/fifo_spi_burst_sequencer.sv
// Drains whole bursts from the sample FIFO into the SPI serializer, framed by cs_n.
// Optional spi_done watchdog in SHIFT: define FIFO_SEQ_TIMEOUT_EN.
module fifo_spi_burst_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int PTR_WIDTH      = 8,
    parameter int BURST_WIDTH    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [BURST_WIDTH-1:0] burst_len,
    fifo_spi_burst_sequencer_if.master bus,
    output logic                   cs_n,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   seq_err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    logic [2:0]             state;
    logic [BURST_WIDTH-1:0] remaining;
    logic [GW-1:0]          gap_cnt;
    logic [PTR_WIDTH:0]     count;
    logic                   start_ok;
    logic                   tmo_hit;

    assign count    = bus.fifo_count;
    assign start_ok = enable && (burst_len != '0) &&
                      (int'(count) >= int'(burst_len));

    assign bus.fifo_rd_en = (state == S_POP) && !bus.fifo_empty;
    assign busy           = (state != S_IDLE);

`ifdef FIFO_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts SHIFT cycles without spi_done; cleared in every other state.
    always_ff @(posedge clk) begin
        if (rst || state != S_SHIFT || bus.spi_done)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (state == S_SHIFT) && !bus.spi_done &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            remaining     <= '0;
            gap_cnt       <= '0;
            bus.spi_data  <= '0;
            bus.spi_start <= 1'b0;
            cs_n          <= 1'b1;
            burst_done    <= 1'b0;
            seq_err       <= 1'b0;
        end else begin
            bus.spi_start <= 1'b0;
            burst_done    <= 1'b0;
            seq_err       <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        remaining <= burst_len;
                        cs_n      <= 1'b0;
                        state     <= S_POP;
                    end
                end
                S_POP: begin
                    if (bus.fifo_empty)
                        seq_err <= 1'b1;
                    else
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    // Data and start leave together so the serializer loads a stable word.
                    bus.spi_data  <= DATA_WIDTH'(bus.fifo_rdata);
                    bus.spi_start <= 1'b1;
                    if (remaining != '0)
                        remaining <= remaining - 1'b1;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (tmo_hit) begin
                        seq_err <= 1'b1;
                        cs_n    <= 1'b1;
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= S_GAP;
                    end else if (bus.spi_done) begin
                        if (remaining == '0) begin
                            burst_done <= 1'b1;
                            cs_n       <= 1'b1;
                            gap_cnt    <= GW'(GAP_CYCLES - 1);
                            state      <= S_GAP;
                        end else begin
                            state <= S_POP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_spi_burst_sequencer.sv
// Directed bench for fifo_spi_burst_sequencer with a FIFO and serializer model.
// Watchdog case needs FIFO_SEQ_TIMEOUT_EN; otherwise SHIFT must wait indefinitely.
module tb_fifo_spi_burst_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] burst_len;
    logic       cs_n, busy, burst_done, seq_err;

    int checks   = 0;
    int failures = 0;

    fifo_spi_burst_sequencer_if #(.DATA_WIDTH(32), .PTR_WIDTH(8)) bus ();

    fifo_spi_burst_sequencer #(
        .DATA_WIDTH(32), .PTR_WIDTH(8), .BURST_WIDTH(8),
        .GAP_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .burst_len(burst_len),
        .bus(bus), .cs_n(cs_n), .busy(busy),
        .burst_done(burst_done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          pops = 0;
    logic        force_en;
    logic        force_empty;
    logic [8:0]  force_cnt;

    assign bus.fifo_count = force_en ? force_cnt : 9'(wr_cnt - rd_cnt);
    assign bus.fifo_empty = force_en ? force_empty : (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            pops <= pops + 1;
            if (!force_en) begin
                bus.fifo_rdata <= mem[rd_cnt & 255];
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    int          dcnt = 0;
    int          done_delay = 34;
    logic        withhold;
    logic [31:0] sent [$];

    always @(posedge clk) begin
        bus.spi_done <= 1'b0;
        if (rst) begin
            dcnt <= 0;
        end else if (bus.spi_start) begin
            sent.push_back(bus.spi_data);
            dcnt <= done_delay;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && !withhold)
                bus.spi_done <= 1'b1;
        end
    end

    int bd_cnt = 0;
    int err_cnt = 0;
    always @(posedge clk) begin
        if (burst_done) bd_cnt <= bd_cnt + 1;
        if (seq_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_cnt & 255] = v;
        wr_cnt++;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tk();
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic wait_bd(input string tag, input int budget);
        int n = 0;
        int b0 = bd_cnt;
        while (bd_cnt == b0 && n < budget) begin
            tk();
            n++;
        end
        check(tag, bd_cnt - b0, 1);
    endtask

    task automatic wait_starts(input string tag, input int target, input int budget);
        int n = 0;
        while (sent.size() < target && n < budget) begin
            tk();
            n++;
        end
        check(tag, sent.size(), target);
    endtask

    initial begin
        int s0, p0, b0, e0, n, bad;
        rst = 1'b1;
        enable = 1'b1;
        burst_len = 8'd2;
        force_en = 1'b1;
        force_empty = 1'b0;
        force_cnt = 9'd10;
        withhold = 1'b0;

        // T1: reset held with a startable configuration
        repeat (3) tk();
        check("t1_cs_n", cs_n, 1);
        check("t1_busy", busy, 0);
        check("t1_rd_en", bus.fifo_rd_en, 0);
        check("t1_start", bus.spi_start, 0);
        check("t1_data", bus.spi_data, 0);
        check("t1_pulses", {burst_done, seq_err}, 0);
        check("t1_pops", pops, 0);
        enable = 1'b0;
        force_en = 1'b0;
        rst = 1'b0;
        tk();

        // T2: one 4-word burst, latency, order and gap
        for (int i = 0; i < 4; i++) push(32'hA5A5_0000 + i);
        burst_len = 8'd4;
        s0 = sent.size();
        p0 = pops;
        b0 = bd_cnt;
        enable = 1'b1;
        tk();
        check("t2_cs_n_n1", cs_n, 0);
        check("t2_rd_en_n1", bus.fifo_rd_en, 1);
        tk();
        check("t2_rd_en_n2", bus.fifo_rd_en, 0);
        tk();
        check("t2_spi_start", bus.spi_start, 1);
        check("t2_first_word", bus.spi_data, 32'hA5A5_0000);
        n = 0;
        bad = 0;
        while (burst_done !== 1'b1 && n < 400) begin
            tk();
            n++;
            if (burst_done !== 1'b1 && cs_n !== 1'b0) bad++;
        end
        check("t2_bd_seen", burst_done, 1);
        check("t2_cs_low", bad, 0);
        n = 0;
        bad = 0;
        while (busy && n < 20) begin
            if (cs_n !== 1'b1) bad++;
            tk();
            n++;
        end
        check("t2_gap_len", n, 4);
        check("t2_gap_cs", bad, 0);
        check("t2_pops", pops - p0, 4);
        check("t2_words", sent.size() - s0, 4);
        for (int i = 0; i < 4; i++)
            if (s0 + i < sent.size())
                check("t2_order", sent[s0 + i], 32'hA5A5_0000 + i);
        check("t2_bd_once", bd_cnt - b0, 1);

        // T3: count one short of burst_len, then reaches it
        for (int i = 0; i < 3; i++) push(32'hB0B0_0000 + i);
        p0 = pops;
        repeat (5) tk();
        check("t3_no_start", busy, 0);
        check("t3_no_pop", pops - p0, 0);
        push(32'hB0B0_0003);
        tk();
        check("t3_start_cs", cs_n, 0);
        check("t3_start_rd", bus.fifo_rd_en, 1);
        wait_bd("t3_bd", 400);
        wait_idle("t3_idle", 20);
        check("t3_last", sent[sent.size() - 1], 32'hB0B0_0003);

        // T4: enable dropped mid-burst, count stays >= burst_len
        burst_len = 8'd5;
        for (int i = 0; i < 10; i++) push(32'hC0C0_0000 + i);
        s0 = sent.size();
        wait_starts("t4_two", s0 + 2, 200);
        enable = 1'b0;
        wait_bd("t4_bd", 400);
        wait_idle("t4_idle", 20);
        n = 0;
        repeat (20) begin
            tk();
            if (busy) n++;
        end
        check("t4_no_restart", n, 0);
        check("t4_words", sent.size() - s0, 5);
        check("t4_last", sent[sent.size() - 1], 32'hC0C0_0004);
        check("t4_count", bus.fifo_count, 5);

        // T5: reset during SHIFT of word 2
        burst_len = 8'd3;
        enable = 1'b1;
        s0 = sent.size();
        wait_starts("t5_two", s0 + 2, 200);
        repeat (3) tk();
        b0 = bd_cnt;
        rst = 1'b1;
        enable = 1'b0;
        tk();
        check("t5_cs_n", cs_n, 1);
        check("t5_busy", busy, 0);
        rst = 1'b0;
        tk();
        check("t5_no_bd", bd_cnt - b0, 0);

        // T6: spi_done withheld
        burst_len = 8'd1;
        withhold = 1'b1;
        enable = 1'b1;
        b0 = bd_cnt;
        e0 = err_cnt;
        n = 0;
        while (!bus.spi_start && n < 20) begin
            tk();
            n++;
        end
        check("t6_start", bus.spi_start, 1);
        enable = 1'b0;
`ifdef FIFO_SEQ_TIMEOUT_EN
        n = 0;
        do begin
            tk();
            n++;
        end while (!seq_err && n < 40);
        check("t6_tmo_lat", n, 16);
        check("t6_cs_n", cs_n, 1);
        wait_idle("t6_idle", 20);
        check("t6_no_bd", bd_cnt - b0, 0);
        check("t6_err_once", err_cnt - e0, 1);
`else
        repeat (40) tk();
        check("t6_still_busy", busy, 1);
        check("t6_cs_low", cs_n, 0);
        check("t6_no_err", err_cnt - e0, 0);
        rst = 1'b1;
        tk();
        rst = 1'b0;
`endif
        withhold = 1'b0;

        // Boundaries: burst_len 0, full FIFO with 255, underrun
        force_en = 1'b1;
        force_empty = 1'b0;
        force_cnt = 9'd256;
        burst_len = 8'd0;
        enable = 1'b1;
        repeat (4) tk();
        check("b_len0", busy, 0);
        burst_len = 8'd255;
        tk();
        check("b_full_cs", cs_n, 0);
        check("b_full_rd", bus.fifo_rd_en, 1);
        rst = 1'b1;
        enable = 1'b0;
        tk();
        rst = 1'b0;
        force_cnt = 9'd2;
        force_empty = 1'b1;
        burst_len = 8'd2;
        enable = 1'b1;
        tk();
        check("b_ur_busy", busy, 1);
        check("b_ur_no_rd", bus.fifo_rd_en, 0);
        tk();
        check("b_ur_err", seq_err, 1);
        rst = 1'b1;
        enable = 1'b0;
        tk();
        rst = 1'b0;
        tk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
endmodule
